// File: rtl/cmp_pkg.sv
// ----------------------------------------------------------------------------
// cmp_pkg
//   Shared definitions for the registered magnitude comparator.
//
//   rel_t packs the three relation flags as {eq, gt, lt}. A valid result
//   always carries exactly one set bit. REL_NONE is the cleared state seen
//   after reset and before the first sampled operand pair.
// ----------------------------------------------------------------------------
package cmp_pkg;

    // {eq, gt, lt}
    typedef logic [2:0] rel_t;

    localparam rel_t REL_EQ   = 3'b100;
    localparam rel_t REL_GT   = 3'b010;
    localparam rel_t REL_LT   = 3'b001;
    localparam rel_t REL_NONE = 3'b000;

    // Collapses the ripple-chain result into a one-hot relation.
    // Less-than is implied whenever the operands are neither equal nor
    // greater, so it never needs its own chain.
    function automatic rel_t rel_from_chain(input logic eq, input logic gt);
        rel_t rel;
        rel = REL_NONE;
        if (eq) begin
            rel = REL_EQ;
        end else if (gt) begin
            rel = REL_GT;
        end else begin
            rel = REL_LT;
        end
        return rel;
    endfunction

endpackage : cmp_pkg

// File: rtl/cmp_bit_slice.sv
// ----------------------------------------------------------------------------
// cmp_bit_slice
//   One bit of an MSB-first ripple magnitude comparator.
//
//   Ports
//     a, b     in   operand bits at this position
//     eq_in    in   all more-significant bits were equal
//     gt_in    in   a more-significant bit already decided A > B
//     eq_out   out  equality carried to the next lower bit
//     gt_out   out  greater-than carried to the next lower bit
//
//   Once a higher bit has decided the relation, eq_in drops and this slice
//   can no longer change the outcome; the decision just passes through.
// ----------------------------------------------------------------------------
module cmp_bit_slice (
    input  logic a,
    input  logic b,
    input  logic eq_in,
    input  logic gt_in,
    output logic eq_out,
    output logic gt_out
);

    assign eq_out = eq_in & ~(a ^ b);
    assign gt_out = gt_in | (eq_in & a & ~b);

endmodule : cmp_bit_slice

// File: rtl/comparator.sv
// ----------------------------------------------------------------------------
// comparator
//   Registered magnitude comparator for two WIDTH-bit operands, unsigned or
//   two's-complement depending on SIGNED. Result flags are one-hot and come
//   straight from flops, so there is no combinational path from A/B to the
//   outputs.
//
//   Parameters
//     WIDTH   operand width in bits (>= 1)
//     SIGNED  0: unsigned compare, 1: two's-complement compare
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     A, B       in   operands
//     in_valid   in   operands are sampled on a rising edge while high
//     AequalsB   out  registered A == B
//     AgreaterB  out  registered A > B
//     AlessB     out  registered A < B
//     out_valid  out  flags hold the result of a sampled operand pair
//
//   Handshake: in_valid is a one-sided valid with no ready; every rising
//   edge with in_valid high captures A/B, and the result plus out_valid=1
//   appear one cycle later. Edges with in_valid low leave the outputs
//   untouched, so a result stays visible until the next sampled pair.
//   out_valid=1 implies exactly one flag is high; out_valid=0 implies all
//   flags are low.
// ----------------------------------------------------------------------------
module comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic             AequalsB,
    output logic             AgreaterB,
    output logic             AlessB,
    output logic             out_valid
);

    // Flipping the sign bit maps two's-complement order onto unsigned
    // order (most negative -> 0, most positive -> all ones), so a single
    // unsigned chain serves both modes.
    localparam logic [WIDTH-1:0] MSB_MASK =
        (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    logic [WIDTH-1:0] a_biased;
    logic [WIDTH-1:0] b_biased;

    assign a_biased = A ^ MSB_MASK;
    assign b_biased = B ^ MSB_MASK;

    // ------------------------------------------------------------------
    // Ripple chain, MSB first. Index WIDTH is the seed above the MSB:
    // "equal so far" and "not yet greater". Index 0 is the final verdict.
    // ------------------------------------------------------------------
    logic [WIDTH:0] eq_chain;
    logic [WIDTH:0] gt_chain;

    assign eq_chain[WIDTH] = 1'b1;
    assign gt_chain[WIDTH] = 1'b0;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        cmp_bit_slice u_slice (
            .a      (a_biased[i]),
            .b      (b_biased[i]),
            .eq_in  (eq_chain[i+1]),
            .gt_in  (gt_chain[i+1]),
            .eq_out (eq_chain[i]),
            .gt_out (gt_chain[i])
        );
    end

    rel_t rel_cmp;

    assign rel_cmp = rel_from_chain(eq_chain[0], gt_chain[0]);

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    rel_t rel_d;
    rel_t rel_q;
    logic out_valid_d;
    logic out_valid_q;

    always_comb begin
        rel_d       = rel_q;
        out_valid_d = out_valid_q;
        if (in_valid) begin
            rel_d       = rel_cmp;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_q       <= REL_NONE;
            out_valid_q <= 1'b0;
        end else begin
            rel_q       <= rel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign AequalsB  = rel_q[2];
    assign AgreaterB = rel_q[1];
    assign AlessB    = rel_q[0];
    assign out_valid = out_valid_q;

endmodule : comparator

// File: tb/tb_comparator.sv
module tb_comparator;

  localparam int W = 2;

  // --------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic in_valid = 1'b0;

  logic u_eq, u_gt, u_lt, u_valid;
  logic s_eq, s_gt, s_lt, s_valid;

  comparator #(.WIDTH(W), .SIGNED(0)) dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a_in),
    .B         (b_in),
    .in_valid  (in_valid),
    .AequalsB  (u_eq),
    .AgreaterB (u_gt),
    .AlessB    (u_lt),
    .out_valid (u_valid)
  );

  comparator #(.WIDTH(W), .SIGNED(1)) dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a_in),
    .B         (b_in),
    .in_valid  (in_valid),
    .AequalsB  (s_eq),
    .AgreaterB (s_gt),
    .AlessB    (s_lt),
    .out_valid (s_valid)
  );

  // --------------------------------------------------------------------
  // Reference model: integer comparison of the operand values
  // --------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  // expected {out_valid, eq, gt, lt}
  logic [3:0] exp_u_q[$];
  logic [3:0] exp_s_q[$];

  bit mdl_valid = 1'b0;
  logic [W-1:0] mdl_a = '0;
  logic [W-1:0] mdl_b = '0;

  function automatic int to_int(input logic [W-1:0] v, input bit sgn);
    int r;
    r = int'(v);
    if (sgn && v[W-1]) r = r - (1 << W);
    return r;
  endfunction

  function automatic logic [3:0] ref_out(input bit sgn);
    int ia, ib;
    if (!mdl_valid) return 4'b0000;
    ia = to_int(mdl_a, sgn);
    ib = to_int(mdl_b, sgn);
    if (ia == ib) return 4'b1100;
    if (ia > ib) return 4'b1010;
    return 4'b1001;
  endfunction

  // --------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------
  task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = v;
    a_in = a;
    b_in = b;
    if (v) begin
      mdl_valid = 1'b1;
      mdl_a = a;
      mdl_b = b;
    end
    exp_u_q.push_back(ref_out(1'b0));
    exp_s_q.push_back(ref_out(1'b1));
  endtask

  task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {v,eq,gt,lt}=%b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      if (exp_u_q.size() == 0 && exp_s_q.size() == 0) return;
      @(posedge clk);
      #2;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", exp_u_q.size(), exp_s_q.size());
    exp_u_q.delete();
    exp_s_q.delete();
  endtask

  // --------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------
  always begin
    @(posedge clk);
    #1;
    if (exp_u_q.size() > 0) check4("unsigned_out", {u_valid, u_eq, u_gt, u_lt}, exp_u_q.pop_front());
    if (exp_s_q.size() > 0) check4("signed_out", {s_valid, s_eq, s_gt, s_lt}, exp_s_q.pop_front());
  end

  // --------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------
  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check4("reset_unsigned", {u_valid, u_eq, u_gt, u_lt}, 4'b0000);
    check4("reset_signed", {s_valid, s_eq, s_gt, s_lt}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // idle after release: nothing changes
    drive(1'b0, 2'd0, 2'd0);
    drive(1'b0, 2'd1, 2'd2);

    // directed: equal, greater, less
    drive(1'b1, 2'd0, 2'd0);
    drive(1'b1, 2'd1, 2'd0);
    drive(1'b1, 2'd0, 2'd1);

    // exhaustive back-to-back, then hold
    for (int i = 0; i < 16; i++) begin
      logic [3:0] p;
      p = 4'(i);
      drive(1'b1, p[3:2], p[1:0]);
    end
    repeat (3) drive(1'b0, 2'd0, 2'd0);

    // signed directed cases (-1 vs +1, -2 vs -2)
    drive(1'b1, 2'b11, 2'b01);
    drive(1'b1, 2'b10, 2'b10);
    drive(1'b0, 2'b01, 2'b11);

    // random traffic with gaps
    for (int i = 0; i < 200; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), W'($urandom_range(0, 3)), W'($urandom_range(0, 3)));
    end

    // mid-stream asynchronous reset
    drive(1'b1, 2'd3, 2'd0);
    drive(1'b0, 2'd0, 2'd0);
    wait_drain();
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    mdl_valid = 1'b0;
    #1;
    check4("async_reset_unsigned", {u_valid, u_eq, u_gt, u_lt}, 4'b0000);
    check4("async_reset_signed", {s_valid, s_eq, s_gt, s_lt}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd3, 2'd3);
    drive(1'b0, 2'd0, 2'd0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_comparator
